// File: rtl/ogpu_raster_pkg.sv
// Shared register map, bit positions and scheduler state encoding for the
// raster command scheduler.
package ogpu_raster_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CMD      = 3'd1;
    localparam logic [2:0] ADDR_CTRL     = 3'd2;
    localparam logic [2:0] ADDR_IRQ      = 3'd3;
    localparam logic [2:0] ADDR_DONE_CNT = 3'd4;

    localparam int STS_BUSY_BIT  = 0;
    localparam int STS_COUNT_LSB = 4;
    localparam int STS_COUNT_MSB = 8;
    localparam int STS_FULL_BIT  = 9;
    localparam int STS_EMPTY_BIT = 10;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_IRQ_DONE_BIT = 1;
    localparam int CTRL_IRQ_ERR_BIT  = 2;
    localparam int CTRL_ABORT_BIT    = 3;

    localparam int IRQ_DONE_BIT = 0;
    localparam int IRQ_ERR_BIT  = 1;
    localparam int IRQ_OVF_BIT  = 2;
    localparam int IRQ_TMO_BIT  = 3;
    localparam int IRQ_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } sched_state_t;

    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic [4:0] count,
        input logic       full,
        input logic       empty
    );
        logic [31:0] s;
        s = 32'd0;
        s[STS_BUSY_BIT]                = busy;
        s[STS_COUNT_MSB:STS_COUNT_LSB] = count;
        s[STS_FULL_BIT]                = full;
        s[STS_EMPTY_BIT]               = empty;
        return s;
    endfunction

endpackage

// File: rtl/ogpu_raster_sched_if.sv
// Host register port plus raster-unit launch/abort/completion handshake.
interface ogpu_raster_sched_if;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;
    logic        rast_start;
    logic [31:0] rast_desc;
    logic        rast_abort;
    logic        rast_done;
    logic        rast_error;

    modport master (
        output avs_address, avs_write, avs_writedata, rast_done, rast_error,
        input  avs_readdata, irq, rast_start, rast_desc, rast_abort
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, rast_done, rast_error,
        output avs_readdata, irq, rast_start, rast_desc, rast_abort
    );
endinterface

// File: rtl/ogpu_cmd_fifo.sv
// Command descriptor FIFO: DEPTH x WIDTH, flush, and push+pop in one cycle
// even when full.
module ogpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_DEPTH);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ogpu_raster_sched.sv
// Raster command scheduler: queues host descriptors, launches them one at a
// time on the raster unit, and tracks completion, errors and hangs.
module ogpu_raster_sched
    import ogpu_raster_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1048576
) (
    input logic                 clk,
    input logic                 reset_n,
    ogpu_raster_sched_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TCNT_ONE = TW'(1);

    sched_state_t        state_r;
    logic [TW-1:0]       tcnt_r;
    logic                rast_start_r;
    logic [31:0]         rast_desc_r;
    logic                rast_abort_r;
    logic                enable_r;
    logic                en_done_r;
    logic                en_err_r;
    logic [IRQ_W-1:0]    irq_r;
    logic [31:0]         done_cnt_r;
    logic [31:0]         avs_readdata_r;

    logic                wr_cmd_s;
    logic                wr_ctrl_s;
    logic                wr_irq_s;
    logic                abort_s;
    logic                push_s;
    logic                pop_s;
    logic                ovf_s;
    logic                done_s;
    logic                tmo_s;
    logic                launch_s;
    logic [IRQ_W-1:0]    irq_set_s;
    logic [IRQ_W-1:0]    irq_clr_s;
    logic [31:0]         rd_mux_s;
    logic [31:0]         fifo_head_s;
    logic [CW-1:0]       fifo_count_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;

    assign wr_cmd_s  = bus.avs_write && (bus.avs_address == ADDR_CMD);
    assign wr_ctrl_s = bus.avs_write && (bus.avs_address == ADDR_CTRL);
    assign wr_irq_s  = bus.avs_write && (bus.avs_address == ADDR_IRQ);

    // Abort overrides every other event of its cycle.
    assign abort_s  = wr_ctrl_s && bus.avs_writedata[CTRL_ABORT_BIT];
    assign push_s   = wr_cmd_s && !abort_s;
    assign pop_s    = (state_r == ST_LAUNCH) && !abort_s;
    assign ovf_s    = push_s && fifo_full_s && !pop_s;
    assign done_s   = (state_r == ST_RUN) && bus.rast_done && !abort_s;
    assign tmo_s    = (state_r == ST_RUN) && !bus.rast_done && (tcnt_r == TMO_LAST) && !abort_s;
    assign launch_s = (state_r == ST_IDLE) && enable_r && !fifo_empty_s && !abort_s;

    ogpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (bus.avs_writedata),
        .pop       (pop_s),
        .flush     (abort_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Interrupt set/clear vectors for this cycle.
    always_comb begin
        irq_set_s                = {IRQ_W{1'b0}};
        irq_set_s[IRQ_DONE_BIT]  = done_s;
        irq_set_s[IRQ_ERR_BIT]   = (done_s && bus.rast_error) || tmo_s;
        irq_set_s[IRQ_OVF_BIT]   = ovf_s;
        irq_set_s[IRQ_TMO_BIT]   = tmo_s;
        if (wr_irq_s) begin
            irq_clr_s = bus.avs_writedata[IRQ_W-1:0];
        end else begin
            irq_clr_s = {IRQ_W{1'b0}};
        end
    end

    // Register read mux; registered below for one-cycle read latency.
    always_comb begin
        rd_mux_s = 32'd0;
        case (bus.avs_address)
            ADDR_STATUS:   rd_mux_s = pack_status(state_r != ST_IDLE, 5'(fifo_count_s),
                                                  fifo_full_s, fifo_empty_s);
            ADDR_CTRL:     rd_mux_s = {29'd0, en_err_r, en_done_r, enable_r};
            ADDR_IRQ:      rd_mux_s = {28'd0, irq_r};
            ADDR_DONE_CNT: rd_mux_s = done_cnt_r;
            default:       rd_mux_s = 32'd0;
        endcase
    end

    // Host-visible control, interrupt flags, completion count and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_r       <= 1'b0;
            en_done_r      <= 1'b0;
            en_err_r       <= 1'b0;
            irq_r          <= {IRQ_W{1'b0}};
            done_cnt_r     <= 32'd0;
            avs_readdata_r <= 32'd0;
        end else begin
            if (wr_ctrl_s) begin
                enable_r  <= bus.avs_writedata[CTRL_EN_BIT];
                en_done_r <= bus.avs_writedata[CTRL_IRQ_DONE_BIT];
                en_err_r  <= bus.avs_writedata[CTRL_IRQ_ERR_BIT];
            end
            irq_r <= (irq_r & ~irq_clr_s) | irq_set_s;
            if (done_s) begin
                done_cnt_r <= done_cnt_r + 32'd1;
            end
            avs_readdata_r <= rd_mux_s;
        end
    end

    // Launch/run sequencer with registered raster-unit outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            tcnt_r       <= {TW{1'b0}};
            rast_start_r <= 1'b0;
            rast_desc_r  <= 32'd0;
            rast_abort_r <= 1'b0;
        end else begin
            rast_start_r <= 1'b0;
            rast_desc_r  <= 32'd0;
            rast_abort_r <= 1'b0;
            if (abort_s) begin
                state_r      <= ST_IDLE;
                tcnt_r       <= {TW{1'b0}};
                rast_abort_r <= (state_r != ST_IDLE);
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (launch_s) begin
                            state_r      <= ST_LAUNCH;
                            rast_start_r <= 1'b1;
                            rast_desc_r  <= fifo_head_s;
                        end
                    end
                    ST_LAUNCH: begin
                        tcnt_r  <= {TW{1'b0}};
                        state_r <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (done_s) begin
                            state_r <= ST_IDLE;
                        end else if (tmo_s) begin
                            state_r      <= ST_IDLE;
                            rast_abort_r <= 1'b1;
                        end else begin
                            tcnt_r <= tcnt_r + TCNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.avs_readdata = avs_readdata_r;
    assign bus.rast_start   = rast_start_r;
    assign bus.rast_desc    = rast_desc_r;
    assign bus.rast_abort   = rast_abort_r;
    assign bus.irq          = (irq_r[IRQ_DONE_BIT] & en_done_r)
                            | ((|irq_r[IRQ_TMO_BIT:IRQ_ERR_BIT]) & en_err_r);

endmodule

// File: doc/ogpu_raster_sched.md
OGPU_RASTER_SCHED -- requirements
Module: ogpu_raster_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command FIFO entries, a power of 2, minimum 2.
REQ-002 SHALL have parameter TIMEOUT, default 1048576: maximum RUN cycles before a command is declared hung.
REQ-003 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port avs_address  in  3  Avalon-MM register word index.
REQ-006 SHALL have port avs_write  in  1  register write strobe.
REQ-007 SHALL have port avs_writedata  in  32  write data.
REQ-008 SHALL have port avs_readdata  out  32  registered read data.
REQ-009 SHALL have port irq  out  1  level interrupt to HPS.
REQ-010 SHALL have port rast_start  out  1  one-cycle launch pulse to the raster unit.
REQ-011 SHALL have port rast_desc  out  32  descriptor address, valid while rast_start=1.
REQ-012 SHALL have port rast_abort  out  1  one-cycle abort pulse to the raster unit.
REQ-013 SHALL have port rast_done  in  1  single-cycle completion pulse from the raster unit.
REQ-014 SHALL have port rast_error  in  1  error qualifier, sampled with rast_done.

Function
REQ-015 SHALL register avs_readdata every cycle from the avs_address mux, giving 1-cycle read latency; reads SHALL have no side effects, and unmapped addresses SHALL read 0.
REQ-016 SHALL map addr 0 STATUS RO: [0] busy (state!=IDLE), [8:4] FIFO count, [9] full, [10] empty.
REQ-017 SHALL map addr 1 CMD WO: a write pushes avs_writedata; if full with no pop that cycle, the data is dropped and IRQ[2] ovf is set.
REQ-018 SHALL map addr 2 CTRL RW: [0] enable, [1] irq_en_done, [2] irq_en_err, [3] abort (write-only, self-clearing, reads 0).
REQ-019 SHALL map addr 3 IRQ RW1C: [0] done, [1] error, [2] ovf, [3] timeout; when set and clear coincide, set wins.
REQ-020 SHALL map addr 4 DONE_CNT RO: 32-bit count of completed commands, wrapping at 2^32-1 -> 0.
REQ-021 SHALL drive irq = (IRQ[0]&irq_en_done) | (|IRQ[3:1] & irq_en_err), combinational from registers.
REQ-022 SHALL implement FSM states IDLE, LAUNCH, RUN.
REQ-023 IDLE SHALL transition to LAUNCH when enable=1 and the FIFO is non-empty.
REQ-024 LAUNCH (1 cycle) SHALL assert rast_start with rast_desc = FIFO head, pop the FIFO, clear the timeout counter, and go to RUN; rast_done in LAUNCH SHALL be ignored.
REQ-025 In RUN, rast_done SHALL increment DONE_CNT, set IRQ[0], set IRQ[1] if rast_error, and return to IDLE.
REQ-026 In RUN, when the counter reaches TIMEOUT-1 without rast_done, the block SHALL set IRQ[1] and IRQ[3], pulse rast_abort, and go to IDLE.
REQ-027 Clearing enable mid-command SHALL let the current command finish; no further launches.
REQ-028 An abort write SHALL flush the FIFO, pulse rast_abort next cycle if state!=IDLE, and force IDLE; it SHALL win over a same-cycle push, rast_done, or launch (no count, no done flag).
REQ-029 A push and pop in the same cycle when full SHALL be accepted with count unchanged.
REQ-030 rast_start and rast_abort SHALL never be high in the same cycle.

Reset
REQ-031 With reset_n low, all registers SHALL be 0, FSM=IDLE, FIFO empty, and avs_readdata, irq, rast_start, rast_abort, rast_desc SHALL be 0; reset mid-RUN SHALL discard state with no rast_abort pulse.

Structure
REQ-032 Package ogpu_raster_pkg SHALL hold register offsets, bit positions, and the FSM state enum.
REQ-033 The FIFO SHALL be a sub-module ogpu_cmd_fifo (DEPTH x 32, count/full/empty, same-cycle push+pop).

Verification
REQ-034 Write CMD 0x1000, CTRL=0x3 -> rast_start with rast_desc=0x1000 two cycles after the CTRL write; rast_done at +10 -> DONE_CNT=1, IRQ=0x1, irq=1; write IRQ=0x1 -> irq=0.
REQ-035 enable=0, write 5 CMDs (DEPTH=4) -> STATUS count=4, full=1, IRQ[2]=1; with irq_en_err=1, irq=1.
REQ-036 TIMEOUT=16, launch, no rast_done -> rast_abort 16 cycles after entering RUN, IRQ=0xA, busy=0.
REQ-037 3 queued CMDs, abort during the first RUN -> rast_abort pulse, count=0, DONE_CNT unchanged, a later rast_done ignored.
REQ-038 rast_done with rast_error=1 -> IRQ=0x3, DONE_CNT+1; an IRQ W1C coinciding with a new done leaves IRQ[0]=1.
REQ-039 Reset asserted mid-RUN -> all outputs 0 the same cycle and no launch after release until a new CMD is written.
